// File: rtl/circle_ctrl_if.sv
// circle_ctrl_if: bundles the start/done handshake and the circle datapath strobe/readback bus.
// Latency: none, this is pure wiring. Only the controller side registers anything.
// Backpressure: level handshakes only. start/done is a hold-until-seen pair, and fill_start/fill_done is the same.
//
// Signals:
//   start, done                  top-level request / completion level pair
//   fill_start, fill_done        fillscreen request / completion level pair
//   draw_circle, octant_sel      plot mux select and octant index (valid while draw_circle=1)
//   load_x, load_y, load_crit    datapath initialisation strobes
//   inc_y, dec_x, calc_crit      datapath per-iteration update strobes
//   offset_x, offset_y, crit     signed readback from the datapath
// Modports:
//   master  the controller side (drives the strobes and done)
//   slave   the datapath / top-level side
interface circle_ctrl_if #(
   parameter int OFFSET_X_DW = 8,
   parameter int OFFSET_Y_DW = 7,
   parameter int CRIT_DW     = 6
);
   logic                          start;
   logic                          done;
   logic                          fill_start;
   logic                          fill_done;
   logic                          draw_circle;
   logic [2:0]                    octant_sel;
   logic                          load_x;
   logic                          load_y;
   logic                          load_crit;
   logic                          inc_y;
   logic                          dec_x;
   logic                          calc_crit;
   logic signed [OFFSET_X_DW-1:0] offset_x;
   logic signed [OFFSET_Y_DW-1:0] offset_y;
   logic signed [CRIT_DW-1:0]     crit;

   modport master (
      input  start, fill_done, offset_x, offset_y, crit,
      output done, fill_start, draw_circle, octant_sel,
             load_x, load_y, load_crit, inc_y, dec_x, calc_crit
   );

   modport slave (
      output start, fill_done, offset_x, offset_y, crit,
      input  done, fill_start, draw_circle, octant_sel,
             load_x, load_y, load_crit, inc_y, dec_x, calc_crit
   );
endinterface

// File: rtl/circle_ctrl.sv
// circle_ctrl: sequences the operation "clear screen (optional), then midpoint circle" over the circle datapath.
// Latency: INIT + 12 cycles per iteration + final CHECK, plus the fill phase when SKIP_FILL=0. Outputs are decoded from state.
// Backpressure: the fill phase waits on fill_done. done holds until start drops, and start is ignored while busy.
//
// Ports:
//   clk     system clock, all state updates on the rising edge
//   resetn  asynchronous active-low reset that returns the block to IDLE with all strobes low
//   bus     circle_ctrl_if.master: the start/done handshake, the fill handshake, datapath strobes and readback
module circle_ctrl #(
   parameter int OFFSET_X_DW = 8,
   parameter int OFFSET_Y_DW = 7,
   parameter int CRIT_DW     = 6,
   parameter bit SKIP_FILL   = 1'b0
) (
   input  logic          clk,
   input  logic          resetn,
   circle_ctrl_if.master bus
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_FILL,
      S_INIT,
      S_CHECK,
      S_PLOT,
      S_INC_Y,
      S_ADJ_X,
      S_CRIT,
      S_DONE
   } state_t;

   // One guard bit above the wider offset, so both offsets sign-extend into a common signed width.
   localparam int CMP_W = ((OFFSET_X_DW > OFFSET_Y_DW) ? OFFSET_X_DW : OFFSET_Y_DW) + 1;

   state_t                    state;
   state_t                    state_nxt;
   logic [2:0]                oct;
   logic [2:0]                oct_nxt;
   logic signed [CMP_W-1:0]   x_ext;
   logic signed [CMP_W-1:0]   y_ext;
   logic                      y_past_x;
   logic                      crit_pos;

   assign x_ext    = {{(CMP_W-OFFSET_X_DW){bus.offset_x[OFFSET_X_DW-1]}}, bus.offset_x};
   assign y_ext    = {{(CMP_W-OFFSET_Y_DW){bus.offset_y[OFFSET_Y_DW-1]}}, bus.offset_y};
   // Termination test. It is signed, so the radius-0 case (offset_x becomes -1) still ends.
   assign y_past_x = (y_ext > x_ext);
   // crit > 0 means the sign bit is clear and the value is nonzero.
   assign crit_pos = ~bus.crit[CRIT_DW-1] & (bus.crit != '0);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= S_IDLE;
         oct   <= 3'd0;
      end else begin
         state <= state_nxt;
         oct   <= oct_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      oct_nxt         = oct;
      bus.done        = 1'b0;
      bus.fill_start  = 1'b0;
      bus.draw_circle = 1'b0;
      bus.octant_sel  = 3'd0;
      bus.load_x      = 1'b0;
      bus.load_y      = 1'b0;
      bus.load_crit   = 1'b0;
      bus.inc_y       = 1'b0;
      bus.dec_x       = 1'b0;
      bus.calc_crit   = 1'b0;

      case (state)
         S_IDLE: begin
            if (bus.start) begin
               state_nxt = SKIP_FILL ? S_INIT : S_FILL;
            end
         end
         S_FILL: begin
            bus.fill_start = 1'b1;
            if (bus.fill_done) begin
               state_nxt = S_INIT;
            end
         end
         S_INIT: begin
            bus.load_x    = 1'b1;
            bus.load_y    = 1'b1;
            bus.load_crit = 1'b1;
            state_nxt     = S_CHECK;
         end
         S_CHECK: begin
            if (y_past_x) begin
               state_nxt = S_DONE;
            end else begin
               state_nxt = S_PLOT;
               oct_nxt   = 3'd0;
            end
         end
         S_PLOT: begin
            bus.draw_circle = 1'b1;
            bus.octant_sel  = oct;
            oct_nxt         = oct + 3'd1;
            if (oct == 3'd7) begin
               state_nxt = S_INC_Y;
            end
         end
         S_INC_Y: begin
            bus.inc_y = 1'b1;
            state_nxt = S_ADJ_X;
         end
         S_ADJ_X: begin
            // This is the only output that is not pure Moore. crit here already reflects the INC_Y step.
            bus.dec_x = crit_pos;
            state_nxt = S_CRIT;
         end
         S_CRIT: begin
            bus.calc_crit = 1'b1;
            state_nxt     = S_CHECK;
         end
         S_DONE: begin
            bus.done = 1'b1;
            if (!bus.start) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule
